pc_fetch_unit: RTL

- Instruction-fetch stage of the MIPS core.
- Owns the program counter and runs a request/acknowledge fetch handshake with instruction memory.
- Presents the fetched instruction and PC+4 to decode.
- Forms the next PC from sequential, branch, J-type and JR sources. For J-type it consumes the 28-bit word-aligned jump field produced by the jump-target shifter and concatenates it with PC+4[31:28].

---
 rtl/pc_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, imem request/ack handshake, next-PC selection.
// Optional build macro MISALIGN_TRAP_EN: misaligned JR traps to TRAP_VEC and pulses fault.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [27:0] jump_target28,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        instr_valid,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] next_pc;
    logic [31:0] imem_addr_nxt, instr_nxt, pc_plus4_nxt;
    logic        imem_req_nxt, instr_valid_nxt;
    logic        consume;

    assign consume = (state == VALID) && !stall;

`ifdef MISALIGN_TRAP_EN
    logic trap;
`endif

    // Redirect priority: jr > jump > branch > sequential, all relative to the consumed instruction.
    always_comb begin
        next_pc = pc_plus4_out;
`ifdef MISALIGN_TRAP_EN
        trap = 1'b0;
`endif
        if (jr) begin
`ifdef MISALIGN_TRAP_EN
            if (jr_addr[1:0] != 2'b00) begin
                next_pc = TRAP_VEC;
                trap    = 1'b1;
            end else begin
                next_pc = jr_addr;
            end
`else
            next_pc = {jr_addr[31:2], 2'b00};
`endif
        end else if (jump) begin
            next_pc = {pc_plus4_out[31:28], jump_target28};
        end else if (branch) begin
            next_pc = pc_plus4_out + branch_offset;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        imem_req_nxt    = imem_req;
        imem_addr_nxt   = imem_addr;
        instr_nxt       = instr_out;
        pc_plus4_nxt    = pc_plus4_out;
        instr_valid_nxt = instr_valid;
        case (state)
            IDLE: begin
                imem_req_nxt  = 1'b1;
                imem_addr_nxt = pc;
                state_nxt     = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_nxt       = imem_rdata;
                    pc_plus4_nxt    = pc + 32'd4;
                    instr_valid_nxt = 1'b1;
                    imem_req_nxt    = 1'b0;
                    state_nxt       = VALID;
                end
            end
            VALID: begin
                if (consume) begin
                    pc_nxt          = next_pc;
                    imem_req_nxt    = 1'b1;
                    imem_addr_nxt   = next_pc;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_out    <= '0;
            pc_plus4_out <= '0;
            instr_valid  <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            imem_req     <= imem_req_nxt;
            imem_addr    <= imem_addr_nxt;
            instr_out    <= instr_nxt;
            pc_plus4_out <= pc_plus4_nxt;
            instr_valid  <= instr_valid_nxt;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault <= 1'b0;
        else     fault <= consume && trap;
    end
`else
    assign fault = 1'b0;
`endif

endmodule
